// File: rtl/hyper_titan_pkg.sv
// rtl/hyper_titan_pkg.sv - shared memory map, link types and field layout for the system controller
package hyper_titan_pkg;

  localparam logic [31:0] SYS_CTRL_START = 32'h0000_2000;
  localparam logic [31:0] SYS_CTRL_END   = 32'h0000_2FFF;

  localparam logic [11:0] REG_OFFSET_CLK_RST_E_CORE      = 12'h000;
  localparam logic [11:0] REG_OFFSET_CLK_RST_P_CORE      = 12'h004;
  localparam logic [11:0] REG_OFFSET_CLK_RST_CORE_LINK   = 12'h008;
  localparam logic [11:0] REG_OFFSET_CLK_RST_SYS_LINK    = 12'h00C;
  localparam logic [11:0] REG_OFFSET_CLK_RST_PERIPH_LINK = 12'h010;
  localparam logic [11:0] REG_OFFSET_BOOT_ADDR_E_CORE    = 12'h040;
  localparam logic [11:0] REG_OFFSET_BOOT_ADDR_P_CORE    = 12'h044;
  localparam logic [11:0] REG_OFFSET_BOOT_HARTID_E_CORE  = 12'h080;
  localparam logic [11:0] REG_OFFSET_BOOT_HARTID_P_CORE  = 12'h084;
  localparam logic [11:0] REG_OFFSET_PLL_CFG_E_CORE      = 12'h0C0;
  localparam logic [11:0] REG_OFFSET_PLL_CFG_P_CORE      = 12'h0C4;
  localparam logic [11:0] REG_OFFSET_PLL_CFG_SYS_LINK    = 12'h0CC;
  localparam logic [11:0] REG_OFFSET_GPR_0               = 12'hFF0;
  localparam logic [11:0] REG_OFFSET_GPR_1               = 12'hFF4;
  localparam logic [11:0] REG_OFFSET_GPR_2               = 12'hFF8;
  localparam logic [11:0] REG_OFFSET_GPR_3               = 12'hFFC;

  localparam int NUM_CLK_RST = 5;
  localparam int NUM_GPR     = 4;

  // Both fields must stay inside byte 0; the write path gates them with wstrb[0].
  localparam int CLK_RST_CLK_EN_BIT = 0;
  localparam int CLK_RST_RST_N_BIT  = 1;

  // Bit order: E-core, P-core, core link, sys link, periph link.
  localparam logic [NUM_CLK_RST-1:0] CLK_RST_CLK_EN_RST = 5'b11101;
  localparam logic [NUM_CLK_RST-1:0] CLK_RST_RST_N_RST  = 5'b11101;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] aw_addr;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic        ar_valid;
    logic        r_ready;
  } pl_sc_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
  } pl_sc_resp_t;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_if.sv
// rtl/axil_reg_if.sv - AXI-Lite handshake front end exposing a flat single-cycle register port
module axil_reg_if
  import hyper_titan_pkg::*;
(
  input  logic        clk_i,
  input  logic        arst_ni,
  input  pl_sc_req_t  req_i,
  output pl_sc_resp_t resp_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_strb_o,
  input  logic        wr_err_i,
  output logic        rd_en_o,
  output logic [31:0] rd_addr_o,
  input  logic [31:0] rd_data_i,
  input  logic        rd_err_i
);

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        aw_held_q, aw_held_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic        w_held_q, w_held_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic [1:0]  b_resp_q, b_resp_d;
  logic [31:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;

  logic aw_ready, w_ready, aw_hs, w_hs;

  // Ready is withheld during W_RESP so only one write is ever outstanding.
  assign aw_ready = (w_state_q == W_IDLE) && !aw_held_q;
  assign w_ready  = (w_state_q == W_IDLE) && !w_held_q;
  assign aw_hs    = req_i.aw_valid && aw_ready;
  assign w_hs     = req_i.w_valid && w_ready;

  // Commit in the cycle the second half of the pair arrives, bypassing the holding regs.
  assign wr_en_o   = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_addr_o = aw_held_q ? aw_addr_q : req_i.aw_addr;
  assign wr_data_o = w_held_q ? w_data_q : req_i.w_data;
  assign wr_strb_o = w_held_q ? w_strb_q : req_i.w_strb;

  assign rd_en_o   = (r_state_q == R_IDLE) && req_i.ar_valid;
  assign rd_addr_o = req_i.ar_addr;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_resp_d  = b_resp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_addr_d = req_i.aw_addr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = req_i.w_data;
          w_strb_d = req_i.w_strb;
        end
        if (wr_en_o) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          b_resp_d  = wr_err_i ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (req_i.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_en_o) begin
          r_data_d  = rd_data_i;
          r_resp_d  = rd_err_i ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (req_i.r_ready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= AXI_RESP_OKAY;
      r_data_q  <= '0;
      r_resp_q  <= AXI_RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_resp_q  <= b_resp_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  always_comb begin
    resp_o          = '0;
    resp_o.aw_ready = aw_ready;
    resp_o.w_ready  = w_ready;
    resp_o.b_valid  = (w_state_q == W_RESP);
    resp_o.b_resp   = b_resp_q;
    resp_o.ar_ready = (r_state_q == R_IDLE);
    resp_o.r_valid  = (r_state_q == R_RESP);
    resp_o.r_data   = r_data_q;
    resp_o.r_resp   = r_resp_q;
  end

endmodule

// File: rtl/sys_ctrl_regs.sv
// rtl/sys_ctrl_regs.sv - system control register file: clock/reset controls, boot config, PLL words, GPRs
module sys_ctrl_regs
  import hyper_titan_pkg::*;
#(
  parameter logic [31:0] E_BOOT_ADDR_RST = 32'h0900_0000,
  parameter logic [31:0] P_BOOT_ADDR_RST = 32'h0900_0000,
  parameter logic [31:0] E_HARTID_RST    = 32'd0,
  parameter logic [31:0] P_HARTID_RST    = 32'd1,
  parameter logic [31:0] PLL_CFG_RST     = 32'd0
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  pl_sc_req_t                    req_i,
  output pl_sc_resp_t                   resp_o,
  output logic [NUM_CLK_RST-1:0]        clk_en_o,
  output logic [NUM_CLK_RST-1:0]        rst_no,
  output logic [31:0]                   boot_addr_e_o,
  output logic [31:0]                   boot_addr_p_o,
  output logic [31:0]                   hartid_e_o,
  output logic [31:0]                   hartid_p_o,
  output logic [31:0]                   pll_cfg_e_o,
  output logic [31:0]                   pll_cfg_p_o,
  output logic [31:0]                   pll_cfg_sl_o,
  output logic [NUM_GPR-1:0][31:0]      gpr_o
);

  localparam logic [9:0] CR_IDX [NUM_CLK_RST] = '{
    REG_OFFSET_CLK_RST_E_CORE[11:2],    REG_OFFSET_CLK_RST_P_CORE[11:2],
    REG_OFFSET_CLK_RST_CORE_LINK[11:2], REG_OFFSET_CLK_RST_SYS_LINK[11:2],
    REG_OFFSET_CLK_RST_PERIPH_LINK[11:2]};
  localparam logic [9:0] GPR_IDX [NUM_GPR] = '{
    REG_OFFSET_GPR_0[11:2], REG_OFFSET_GPR_1[11:2],
    REG_OFFSET_GPR_2[11:2], REG_OFFSET_GPR_3[11:2]};
  localparam logic [9:0] IDX_BOOT_E = REG_OFFSET_BOOT_ADDR_E_CORE[11:2];
  localparam logic [9:0] IDX_BOOT_P = REG_OFFSET_BOOT_ADDR_P_CORE[11:2];
  localparam logic [9:0] IDX_HART_E = REG_OFFSET_BOOT_HARTID_E_CORE[11:2];
  localparam logic [9:0] IDX_HART_P = REG_OFFSET_BOOT_HARTID_P_CORE[11:2];
  localparam logic [9:0] IDX_PLL_E  = REG_OFFSET_PLL_CFG_E_CORE[11:2];
  localparam logic [9:0] IDX_PLL_P  = REG_OFFSET_PLL_CFG_P_CORE[11:2];
  localparam logic [9:0] IDX_PLL_SL = REG_OFFSET_PLL_CFG_SYS_LINK[11:2];

  logic                     wr_en, wr_err, rd_en, rd_err;
  logic [31:0]              wr_addr, wr_data, rd_addr, rd_data;
  logic [3:0]               wr_strb;
  logic [9:0]               wr_idx, rd_idx;
  logic                     unused_addr;

  logic [NUM_CLK_RST-1:0]   clk_en_q, clk_en_d, rst_n_q, rst_n_d;
  logic [31:0]              boot_e_q, boot_e_d, boot_p_q, boot_p_d;
  logic [31:0]              hart_e_q, hart_e_d, hart_p_q, hart_p_d;
  logic [31:0]              pll_e_q, pll_e_d, pll_p_q, pll_p_d, pll_sl_q, pll_sl_d;
  logic [NUM_GPR-1:0][31:0] gpr_q, gpr_d;

  axil_reg_if u_if (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .req_i     (req_i),
    .resp_o    (resp_o),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .wr_err_i  (wr_err),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data),
    .rd_err_i  (rd_err)
  );

  // Only the word index within the 4 KiB window takes part in decode.
  assign wr_idx      = wr_addr[11:2];
  assign rd_idx      = rd_addr[11:2];
  assign unused_addr = ^{wr_addr[31:12], wr_addr[1:0], rd_addr[31:12], rd_addr[1:0], rd_en};

  function automatic logic [31:0] cr_word(input logic en, input logic rn);
    logic [31:0] w;
    w = '0;
    w[CLK_RST_CLK_EN_BIT] = en;
    w[CLK_RST_RST_N_BIT]  = rn;
    return w;
  endfunction

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    for (int k = 0; k < NUM_CLK_RST; k++) begin
      if (rd_idx == CR_IDX[k]) begin
        rd_data = cr_word(clk_en_q[k], rst_n_q[k]);
        rd_err  = 1'b0;
      end
    end
    for (int k = 0; k < NUM_GPR; k++) begin
      if (rd_idx == GPR_IDX[k]) begin
        rd_data = gpr_q[k];
        rd_err  = 1'b0;
      end
    end
    case (rd_idx)
      IDX_BOOT_E: begin rd_data = boot_e_q; rd_err = 1'b0; end
      IDX_BOOT_P: begin rd_data = boot_p_q; rd_err = 1'b0; end
      IDX_HART_E: begin rd_data = hart_e_q; rd_err = 1'b0; end
      IDX_HART_P: begin rd_data = hart_p_q; rd_err = 1'b0; end
      IDX_PLL_E:  begin rd_data = pll_e_q;  rd_err = 1'b0; end
      IDX_PLL_P:  begin rd_data = pll_p_q;  rd_err = 1'b0; end
      IDX_PLL_SL: begin rd_data = pll_sl_q; rd_err = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    clk_en_d = clk_en_q;
    rst_n_d  = rst_n_q;
    boot_e_d = boot_e_q;
    boot_p_d = boot_p_q;
    hart_e_d = hart_e_q;
    hart_p_d = hart_p_q;
    pll_e_d  = pll_e_q;
    pll_p_d  = pll_p_q;
    pll_sl_d = pll_sl_q;
    gpr_d    = gpr_q;
    wr_err   = 1'b1;
    for (int k = 0; k < NUM_CLK_RST; k++) begin
      if (wr_idx == CR_IDX[k]) begin
        wr_err = 1'b0;
        if (wr_en && wr_strb[0]) begin
          clk_en_d[k] = wr_data[CLK_RST_CLK_EN_BIT];
          rst_n_d[k]  = wr_data[CLK_RST_RST_N_BIT];
        end
      end
    end
    for (int k = 0; k < NUM_GPR; k++) begin
      if (wr_idx == GPR_IDX[k]) begin
        wr_err = 1'b0;
        if (wr_en) gpr_d[k] = apply_wstrb(gpr_q[k], wr_data, wr_strb);
      end
    end
    case (wr_idx)
      IDX_BOOT_E: begin wr_err = 1'b0; if (wr_en) boot_e_d = apply_wstrb(boot_e_q, wr_data, wr_strb); end
      IDX_BOOT_P: begin wr_err = 1'b0; if (wr_en) boot_p_d = apply_wstrb(boot_p_q, wr_data, wr_strb); end
      IDX_HART_E: begin wr_err = 1'b0; if (wr_en) hart_e_d = apply_wstrb(hart_e_q, wr_data, wr_strb); end
      IDX_HART_P: begin wr_err = 1'b0; if (wr_en) hart_p_d = apply_wstrb(hart_p_q, wr_data, wr_strb); end
      IDX_PLL_E:  begin wr_err = 1'b0; if (wr_en) pll_e_d  = apply_wstrb(pll_e_q,  wr_data, wr_strb); end
      IDX_PLL_P:  begin wr_err = 1'b0; if (wr_en) pll_p_d  = apply_wstrb(pll_p_q,  wr_data, wr_strb); end
      IDX_PLL_SL: begin wr_err = 1'b0; if (wr_en) pll_sl_d = apply_wstrb(pll_sl_q, wr_data, wr_strb); end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      clk_en_q <= CLK_RST_CLK_EN_RST;
      rst_n_q  <= CLK_RST_RST_N_RST;
      boot_e_q <= E_BOOT_ADDR_RST;
      boot_p_q <= P_BOOT_ADDR_RST;
      hart_e_q <= E_HARTID_RST;
      hart_p_q <= P_HARTID_RST;
      pll_e_q  <= PLL_CFG_RST;
      pll_p_q  <= PLL_CFG_RST;
      pll_sl_q <= PLL_CFG_RST;
      gpr_q    <= '0;
    end else begin
      clk_en_q <= clk_en_d;
      rst_n_q  <= rst_n_d;
      boot_e_q <= boot_e_d;
      boot_p_q <= boot_p_d;
      hart_e_q <= hart_e_d;
      hart_p_q <= hart_p_d;
      pll_e_q  <= pll_e_d;
      pll_p_q  <= pll_p_d;
      pll_sl_q <= pll_sl_d;
      gpr_q    <= gpr_d;
    end
  end

  assign clk_en_o      = clk_en_q;
  assign rst_no        = rst_n_q;
  assign boot_addr_e_o = boot_e_q;
  assign boot_addr_p_o = boot_p_q;
  assign hartid_e_o    = hart_e_q;
  assign hartid_p_o    = hart_p_q;
  assign pll_cfg_e_o   = pll_e_q;
  assign pll_cfg_p_o   = pll_p_q;
  assign pll_cfg_sl_o  = pll_sl_q;
  assign gpr_o         = gpr_q;

endmodule
